// File: rtl/nlc_horner_seq.sv
// Time-multiplexed polynomial nonlinearity correction: one shared multiply-add walks every
// channel through Horner's rule, then all channel results are published together.
module nlc_horner_seq #(
    parameter int NUM_CH = 16,
    parameter int ORDER  = 5,
    parameter int DW     = 21,
    parameter int CW     = 32,
    parameter int FRAC   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           srdyi,
    input  logic                           bypass_i,
    input  logic [NUM_CH*DW-1:0]           x_adc_i,
    input  logic [NUM_CH*(ORDER+1)*CW-1:0] coeff_i,
    output logic [NUM_CH*DW-1:0]           x_lin_o,
    output logic                           srdyo,
    output logic                           busy_o,
    output logic                           sat_o,
    output logic                           overrun_o
);

    localparam int NK  = ORDER + 1;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int KW  = $clog2(NK);
    localparam int PW  = CW + DW;
    localparam int SW  = CW + DW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;

    state_t                          state_q, state_d;
    logic [CHW-1:0]                  ch_q, ch_d;
    logic [KW-1:0]                   k_q, k_d;
    logic signed [CW-1:0]            acc_q, acc_d;
    logic [NUM_CH*DW-1:0]            x_q, x_d;
    logic [NUM_CH*NK*CW-1:0]         coef_q, coef_d;
    logic [NUM_CH*DW-1:0]            res_q, res_d;
    logic [NUM_CH*DW-1:0]            xlin_q, xlin_d;
    logic                            runsat_q, runsat_d;
    logic                            sat_q, sat_d;
    logic                            srdyo_q, srdyo_d;
    logic                            ovr_q, ovr_d;

    int                              kk;
    logic signed [DW-1:0]            x_sel;
    logic signed [CW-1:0]            coef_sel;
    logic signed [PW-1:0]            prod;
    logic signed [SW-1:0]            sum;
    logic signed [CW-1:0]            acc_step;
    logic signed [DW-1:0]            res_val;
    logic                            ovf_c, ovf_d;

    // A value fits the narrower width when all bits from its new sign bit upward agree.
    function automatic logic ovf_cw(input logic signed [SW-1:0] v);
        return !((&v[SW-1:CW-1]) || !(|v[SW-1:CW-1]));
    endfunction

    function automatic logic signed [CW-1:0] sat_cw(input logic signed [SW-1:0] v);
        if (ovf_cw(v))
            return v[SW-1] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
        return v[CW-1:0];
    endfunction

    function automatic logic ovf_dw(input logic signed [CW-1:0] v);
        return !((&v[CW-1:DW-1]) || !(|v[CW-1:DW-1]));
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [CW-1:0] v);
        if (ovf_dw(v))
            return v[CW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return v[DW-1:0];
    endfunction

    always_comb begin
        kk       = (state_q == STEP) ? int'(k_q) : ORDER;
        x_sel    = x_q[int'(ch_q)*DW +: DW];
        coef_sel = coef_q[(int'(ch_q)*NK + kk)*CW +: CW];
        prod     = PW'(acc_q) * PW'(x_sel);
        // >>> on a signed operand floors toward -inf, which is the intended truncation.
        sum      = (SW'(prod) >>> FRAC) + SW'(coef_sel);
        acc_step = sat_cw(sum);
        ovf_c    = ovf_cw(sum);
        res_val  = sat_dw(acc_step);
        ovf_d    = ovf_dw(acc_step);
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        k_d      = k_q;
        acc_d    = acc_q;
        x_d      = x_q;
        coef_d   = coef_q;
        res_d    = res_q;
        xlin_d   = xlin_q;
        runsat_d = runsat_q;
        sat_d    = sat_q;
        srdyo_d  = 1'b0;
        ovr_d    = ovr_q;

        if (srdyi && (state_q != IDLE))
            ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (srdyi) begin
                    x_d      = x_adc_i;
                    coef_d   = coeff_i;
                    ch_d     = '0;
                    runsat_d = 1'b0;
                    if (bypass_i) begin
                        res_d   = x_adc_i;
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                acc_d   = coef_sel;
                k_d     = KW'(ORDER - 1);
                state_d = STEP;
            end
            STEP: begin
                acc_d = acc_step;
                if (ovf_c)
                    runsat_d = 1'b1;
                if (k_q == '0) begin
                    res_d[int'(ch_q)*DW +: DW] = res_val;
                    if (ovf_d)
                        runsat_d = 1'b1;
                    if (ch_q == CHW'(NUM_CH - 1)) begin
                        state_d = DONE;
                    end else begin
                        ch_d    = ch_q + CHW'(1);
                        state_d = LOAD;
                    end
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            DONE: begin
                xlin_d  = res_q;
                sat_d   = runsat_q;
                srdyo_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            coef_q   <= '0;
            res_q    <= '0;
            xlin_q   <= '0;
            runsat_q <= 1'b0;
            sat_q    <= 1'b0;
            srdyo_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
            res_q    <= res_d;
            xlin_q   <= xlin_d;
            runsat_q <= runsat_d;
            sat_q    <= sat_d;
            srdyo_q  <= srdyo_d;
            ovr_q    <= ovr_d;
        end
    end

    assign x_lin_o   = xlin_q;
    assign srdyo     = srdyo_q;
    assign busy_o    = (state_q != IDLE);
    assign sat_o     = sat_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_nlc_horner_seq.sv
// Randomised and directed scoreboard bench for nlc_horner_seq at its default parameters.
module tb_nlc_horner_seq;

    localparam int N  = 16;
    localparam int O  = 5;
    localparam int NK = O + 1;
    localparam int DW = 21;
    localparam int CW = 32;
    localparam int F  = 16;
    localparam int XW = N * DW;
    localparam int CT = N * NK * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          srdyi = 1'b0;
    logic          bypass = 1'b0;
    logic [XW-1:0] x_adc = '0;
    logic [CT-1:0] coeff = '0;
    logic [XW-1:0] x_lin;
    logic          srdyo, busy, sat, overrun;

    nlc_horner_seq #(.NUM_CH(N), .ORDER(O), .DW(DW), .CW(CW), .FRAC(F)) dut (
        .clk(clk), .reset(rst), .srdyi(srdyi), .bypass_i(bypass),
        .x_adc_i(x_adc), .coeff_i(coeff), .x_lin_o(x_lin), .srdyo(srdyo),
        .busy_o(busy), .sat_o(sat), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] r;
        bit            s;
        longint        e0;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    longint        cyc = 0;
    int            total = 0;
    int            bad = 0;
    logic [XW-1:0] held = '0;
    bit            held_s = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [XW-1:0] got, input logic [XW-1:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Polynomial evaluated directly with floor division and clamping on 64-bit integers.
    function automatic void ref_model(input logic [XW-1:0] xv, input logic [CT-1:0] cv, input bit byp,
                                      output logic [XW-1:0] r, output bit s);
        longint cmax = (longint'(1) <<< (CW - 1)) - 1;
        longint cmin = -cmax - 1;
        longint dmax = (longint'(1) <<< (DW - 1)) - 1;
        longint dmin = -dmax - 1;
        longint den  = longint'(1) <<< F;
        longint xi, acc, p, q;
        s = 1'b0;
        r = '0;
        for (int c = 0; c < N; c++) begin
            if (byp) begin
                r[c*DW +: DW] = xv[c*DW +: DW];
            end else begin
                xi  = longint'($signed(xv[c*DW +: DW]));
                acc = longint'($signed(cv[(c*NK + O)*CW +: CW]));
                for (int k = O - 1; k >= 0; k--) begin
                    p = acc * xi;
                    q = p / den;
                    if (p < 0 && q * den != p) q = q - 1;
                    acc = q + longint'($signed(cv[(c*NK + k)*CW +: CW]));
                    if (acc > cmax) begin acc = cmax; s = 1'b1; end
                    else if (acc < cmin) begin acc = cmin; s = 1'b1; end
                end
                if (acc > dmax) begin acc = dmax; s = 1'b1; end
                else if (acc < dmin) begin acc = dmin; s = 1'b1; end
                r[c*DW +: DW] = acc[DW-1:0];
            end
        end
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk(1'b0, "idle_timeout", XW'(busy), '0);
    endtask

    task automatic issue(input logic [XW-1:0] xv, input logic [CT-1:0] cv, input bit byp,
                         input logic [XW-1:0] er, input bit es);
        exp_t e;
        wait_idle();
        x_adc  = xv;
        coeff  = cv;
        bypass = byp;
        srdyi  = 1'b1;
        @(posedge clk);
        #1;
        srdyi  = 1'b0;
        bypass = 1'b0;
        e.r   = er;
        e.s   = es;
        e.e0  = cyc;
        e.lat = byp ? 1 : N * NK + 1;
        sb.push_back(e);
    endtask

    function automatic logic [XW-1:0] splat(input int v);
        logic [XW-1:0] r;
        for (int c = 0; c < N; c++) r[c*DW +: DW] = v[DW-1:0];
        return r;
    endfunction

    // Coefficient vector with the same c1 and c0 on every channel, higher terms zero.
    function automatic logic [CT-1:0] coef_lo(input int c1, input int c0);
        logic [CT-1:0] r = '0;
        for (int c = 0; c < N; c++) begin
            r[(c*NK + 1)*CW +: CW] = c1;
            r[(c*NK)*CW +: CW]     = c0;
        end
        return r;
    endfunction

    task automatic rand_run(input int mode);
        logic [XW-1:0] xv, er;
        logic [CT-1:0] cv;
        logic [31:0]   t;
        int            v;
        bit            es;
        for (int c = 0; c < N; c++) begin
            if (mode == 0) v = int'($urandom_range(0, 2 * 131072)) - 131072;
            else v = int'($urandom);
            t = v;
            xv[c*DW +: DW] = t[DW-1:0];
        end
        for (int i = 0; i < N * NK; i++) begin
            if (mode == 0) v = int'($urandom_range(0, 2 * 32768)) - 32768;
            else v = int'($urandom);
            cv[i*CW +: CW] = v;
        end
        ref_model(xv, cv, mode == 2, er, es);
        issue(xv, cv, mode == 2, er, es);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) continue;
            if (srdyo) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_srdyo", x_lin, held);
                end else begin
                    e = sb.pop_front();
                    chk(x_lin == e.r, "x_lin", x_lin, e.r);
                    chk(sat == e.s, "sat", XW'(sat), XW'(e.s));
                    chk(cyc - e.e0 == longint'(e.lat), "latency", XW'(cyc - e.e0), XW'(e.lat));
                    held   = e.r;
                    held_s = e.s;
                end
            end else begin
                chk(x_lin == held, "x_lin_hold", x_lin, held);
                chk(sat == held_s, "sat_hold", XW'(sat), XW'(held_s));
            end
        end
    end

    initial begin : stim
        int n;
        logic [XW-1:0] er;
        bit es;
        logic [XW-1:0] xv;
        logic [CT-1:0] cv;

        repeat (3) @(posedge clk);
        #1;
        chk(x_lin == '0, "rst_x_lin", x_lin, '0);
        chk({srdyo, busy, sat, overrun} == 4'b0, "rst_flags", XW'({srdyo, busy, sat, overrun}), '0);
        @(negedge clk);
        rst = 1'b0;

        // Unity gain, truncation toward -inf, clamping both ways, bypass.
        issue(splat(12345), coef_lo(32'h0001_0000, 0), 1'b0, splat(12345), 1'b0);
        issue(splat(-3), coef_lo(32'h0000_8000, 0), 1'b0, splat(-2), 1'b0);
        issue(splat(3), coef_lo(32'h0000_8000, 0), 1'b0, splat(1), 1'b0);
        issue(splat(0), coef_lo(0, 2000000), 1'b0, splat(1048575), 1'b1);
        issue(splat(0), coef_lo(0, -2000000), 1'b0, splat(-1048576), 1'b1);
        issue(splat(-777), coef_lo(5, 5), 1'b1, splat(-777), 1'b0);

        for (int i = 0; i < 12; i++) rand_run(int'($urandom_range(0, 2)));

        // A request during a run is flagged and otherwise ignored.
        wait_idle();
        chk(overrun == 1'b0, "overrun_before", XW'(overrun), '0);
        rand_run(0);
        repeat (10) @(negedge clk);
        x_adc = ~x_adc;
        srdyi = 1'b1;
        @(negedge clk);
        srdyi = 1'b0;
        chk(overrun == 1'b1, "overrun_set", XW'(overrun), XW'(1));
        rand_run(1);
        wait_idle();
        chk(overrun == 1'b1, "overrun_sticky", XW'(overrun), XW'(1));

        // Reset in the middle of a run aborts it without a result.
        rand_run(0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        held   = '0;
        held_s = 1'b0;
        #1;
        chk(x_lin == '0, "midrst_x_lin", x_lin, '0);
        chk({srdyo, busy, sat, overrun} == 4'b0, "midrst_flags", XW'({srdyo, busy, sat, overrun}), '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) rand_run(int'($urandom_range(0, 2)));
        issue(splat(12345), coef_lo(32'h0001_0000, 0), 1'b0, splat(12345), 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) chk(1'b0, "drain_timeout", XW'(sb.size()), '0);
        repeat (3) @(posedge clk);
        #2;
        chk(overrun == 1'b0, "overrun_cleared", XW'(overrun), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
